led_frame_buffer: RTL and testbench

- Double-banked pixel store and frame-trigger sequencer directly upstream of the WS2812B serial driver.
- A host writes per-LED RGB into the back bank, then commits. The block swaps banks and raises update_frame.
- It serves the driver's program_led_number index with zero-latency RGB reads from the front bank.
- It drops the trigger when it sees the driver wrap past the last LED, then enforces a guard interval before the next frame.

---
 rtl/led_frame_buffer.sv | 187 ++++++++++++++++++
 tb/tb_led_frame_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_buffer.sv
// led_frame_buffer
// Double-banked RGB pixel store feeding a WS2812B serial driver. The host
// fills the back bank and commits; the block swaps banks, raises
// update_frame, serves zero-latency reads from the front bank, drops the
// trigger when the driver wraps past the last LED, then holds off for a
// guard interval before another frame may start.

module led_frame_buffer #(
    parameter int MAX_POS      = 16,
    parameter int GUARD_CYCLES = 2700
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(MAX_POS)-1:0] wr_addr,
    input  logic [7:0]                 wr_red,
    input  logic [7:0]                 wr_green,
    input  logic [7:0]                 wr_blue,
    output logic                       wr_err,
    input  logic                       commit,
    output logic                       frame_busy,
    output logic                       update_frame,
    input  logic [$clog2(MAX_POS)-1:0] program_led_number,
    output logic [7:0]                 program_red_intensity,
    output logic [7:0]                 program_green_intensity,
    output logic [7:0]                 program_blue_intensity
);

    localparam int AW = $clog2(MAX_POS);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    // Indices are compared one bit wider so a non-power-of-two chain length
    // can reject the unused top of the address space.
    localparam logic [AW:0]   POS_LIMIT  = (AW+1)'(MAX_POS);
    localparam logic [AW-1:0] LAST_POS   = AW'(MAX_POS - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SENDING = 2'd1,
        GUARD   = 2'd2
    } state_t;

    logic [23:0]   r_bank0 [MAX_POS];
    logic [23:0]   r_bank1 [MAX_POS];
    logic          r_frontSel;
    logic          r_pending;
    state_t        r_state;
    logic          r_updateFrame;
    logic          r_wrReady;
    logic          r_wrErr;
    logic          r_busy;
    logic [GW-1:0] r_guardCnt;
    logic [AW-1:0] r_prevLed;

    logic          w_wrAccept;
    logic          w_wrInRange;
    logic          w_rdInRange;
    logic          w_commitTake;
    logic          w_frameEnd;
    logic          w_swap;
    state_t        w_stateNext;
    logic          w_updateNext;
    logic [GW-1:0] w_guardNext;
    logic          w_pendingNext;
    logic          w_wrReadyNext;
    logic [23:0]   w_frontPix;

    assign w_wrAccept   = wr_valid & r_wrReady;
    assign w_wrInRange  = ({1'b0, wr_addr} < POS_LIMIT);
    assign w_rdInRange  = ({1'b0, program_led_number} < POS_LIMIT);
    assign w_commitTake = commit & ~r_pending;
    assign w_frameEnd   = (r_prevLed == LAST_POS) && (program_led_number == '0);

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        w_stateNext   = r_state;
        w_swap        = 1'b0;
        w_updateNext  = r_updateFrame;
        w_guardNext   = r_guardCnt;
        w_pendingNext = r_pending;
        w_wrReadyNext = r_wrReady;

        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_swap       = 1'b1;
                    w_updateNext = 1'b1;
                    w_stateNext  = SENDING;
                end
            end
            SENDING: begin
                w_updateNext = 1'b1;
                if (w_frameEnd) begin
                    w_updateNext = 1'b0;
                    w_guardNext  = GUARD_LOAD;
                    w_stateNext  = GUARD;
                end
            end
            GUARD: begin
                w_updateNext = 1'b0;
                if (r_guardCnt != '0) begin
                    w_guardNext = r_guardCnt - 1'b1;
                end
                if (r_guardCnt <= GW'(1)) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_updateNext = 1'b0;
                w_stateNext  = IDLE;
            end
        endcase

        if (w_swap) begin
            w_pendingNext = 1'b0;
            w_wrReadyNext = 1'b1;
        end else if (w_commitTake) begin
            w_pendingNext = 1'b1;
            w_wrReadyNext = 1'b0;
        end
    end

    // Sequencer state, handshake flags and the driver index history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_frontSel    <= 1'b0;
            r_pending     <= 1'b0;
            r_updateFrame <= 1'b0;
            r_wrReady     <= 1'b1;
            r_busy        <= 1'b0;
            r_guardCnt    <= '0;
            r_prevLed     <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_pending     <= w_pendingNext;
            r_updateFrame <= w_updateNext;
            r_wrReady     <= w_wrReadyNext;
            r_busy        <= r_pending | (r_state != IDLE);
            r_guardCnt    <= w_guardNext;
            r_prevLed     <= program_led_number;
            if (w_swap) begin
                r_frontSel <= ~r_frontSel;
            end
        end
    end

    // Host write port into whichever bank is currently the back bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrErr <= 1'b0;
            for (int i = 0; i < MAX_POS; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
        end else begin
            r_wrErr <= w_wrAccept & ~w_wrInRange;
            if (w_wrAccept && w_wrInRange) begin
                if (r_frontSel) begin
                    r_bank0[wr_addr] <= {wr_red, wr_green, wr_blue};
                end else begin
                    r_bank1[wr_addr] <= {wr_red, wr_green, wr_blue};
                end
            end
        end
    end

    // Zero-latency front-bank read for the driver; out-of-range reads black.
    always_comb begin
        w_frontPix = '0;
        if (w_rdInRange) begin
            w_frontPix = r_frontSel ? r_bank1[program_led_number]
                                    : r_bank0[program_led_number];
        end
    end

    assign wr_ready                = r_wrReady;
    assign wr_err                  = r_wrErr;
    assign frame_busy              = r_busy;
    assign update_frame            = r_updateFrame;
    assign program_red_intensity   = w_frontPix[23:16];
    assign program_green_intensity = w_frontPix[15:8];
    assign program_blue_intensity  = w_frontPix[7:0];

endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer
// Directed bench for led_frame_buffer with a six-LED chain (so that
// out-of-range addresses are representable) and an eight-cycle guard.
// A small bank model predicts read data; expected pixels are queued when an
// index is driven and popped when the combinational read settles.

module tb_led_frame_buffer;

    localparam int MAXP  = 6;
    localparam int GUARD = 8;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_red;
    logic [7:0] wr_green;
    logic [7:0] wr_blue;
    logic       wr_err;
    logic       commit;
    logic       frame_busy;
    logic       update_frame;
    logic [2:0] program_led_number;
    logic [7:0] program_red_intensity;
    logic [7:0] program_green_intensity;
    logic [7:0] program_blue_intensity;

    typedef struct {
        string       tag;
        logic [23:0] exp;
    } sbEntry_t;

    sbEntry_t    sbQueue[$];
    logic [23:0] mBank [2][MAXP];
    int          mFront;
    bit          mPending;
    bit          mReady;
    int          checks;
    int          errors;

    led_frame_buffer #(
        .MAX_POS      (MAXP),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .wr_valid                (wr_valid),
        .wr_ready                (wr_ready),
        .wr_addr                 (wr_addr),
        .wr_red                  (wr_red),
        .wr_green                (wr_green),
        .wr_blue                 (wr_blue),
        .wr_err                  (wr_err),
        .commit                  (commit),
        .frame_busy              (frame_busy),
        .update_frame            (update_frame),
        .program_led_number      (program_led_number),
        .program_red_intensity   (program_red_intensity),
        .program_green_intensity (program_green_intensity),
        .program_blue_intensity  (program_blue_intensity)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < MAXP; i++) begin
                mBank[b][i] = '0;
            end
        end
        mFront   = 0;
        mPending = 1'b0;
        mReady   = 1'b1;
    endtask

    task automatic modelSwap();
        mFront   = 1 - mFront;
        mPending = 1'b0;
        mReady   = 1'b1;
    endtask

    function automatic logic [23:0] modelPix(input int idx);
        if (idx < MAXP) return mBank[mFront][idx];
        return '0;
    endfunction

    // Drive one cycle of host activity and apply its effect to the model.
    task automatic applyStimulus(input bit wv, input logic [2:0] a, input logic [7:0] r,
                                 input logic [7:0] g, input logic [7:0] b, input bit c);
        wr_valid = wv;
        wr_addr  = a;
        wr_red   = r;
        wr_green = g;
        wr_blue  = b;
        commit   = c;
        if (wv && mReady && (int'(a) < MAXP)) mBank[1 - mFront][a] = {r, g, b};
        if (c && !mPending) begin
            mPending = 1'b1;
            mReady   = 1'b0;
        end
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    // Drive a read index, queue the predicted pixel, compare once settled.
    task automatic readCheck(input string tag, input int idx);
        sbEntry_t e;
        program_led_number = 3'(idx);
        sbQueue.push_back('{tag: tag, exp: modelPix(idx)});
        #1;
        e = sbQueue.pop_front();
        checkOutput(e.tag, {program_red_intensity, program_green_intensity, program_blue_intensity}, e.exp);
    endtask

    // Commit (optionally with a simultaneous write) and expect the swap one cycle on.
    task automatic startFrame(input bit wv, input logic [2:0] a, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b);
        applyStimulus(wv, a, r, g, b, 1'b1);
        checkOutput("upd_after_commit", {23'd0, update_frame}, 24'd0);
        checkOutput("rdy_after_commit", {23'd0, wr_ready}, 24'd0);
        tick();
        modelSwap();
        checkOutput("upd_rise", {23'd0, update_frame}, 24'd1);
        checkOutput("rdy_after_swap", {23'd0, wr_ready}, 24'd1);
        checkOutput("busy_sending", {23'd0, frame_busy}, 24'd1);
    endtask

    // Walk the driver index 1..MAXP-1 then wrap to 0; write idx3 on the way.
    task automatic sweepFrame(input int cA, input int cB);
        for (int i = 1; i < MAXP; i++) begin
            readCheck("rd_sweep", i);
            if (i == cA || i == cB) applyStimulus(1'b0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b1);
            else if (i == 3)        applyStimulus(1'b1, 3'd3, 8'h44, 8'h45, 8'h46, 1'b0);
            else                    tick();
        end
        readCheck("rd_wrap", 0);
        checkOutput("upd_before_wrap", {23'd0, update_frame}, 24'd1);
        tick();
        checkOutput("upd_fall", {23'd0, update_frame}, 24'd0);
    endtask

    // Guard interval: busy held, trigger low, then either idle or the next swap.
    task automatic guardWait();
        checkOutput("busy_at_fall", {23'd0, frame_busy}, 24'd1);
        for (int i = 1; i < GUARD; i++) begin
            tick();
            checkOutput("upd_guard", {23'd0, update_frame}, 24'd0);
            checkOutput("busy_guard", {23'd0, frame_busy}, 24'd1);
            checkOutput("rdy_guard", {23'd0, wr_ready}, {23'd0, mReady});
        end
        tick();
        if (mPending) begin
            modelSwap();
            checkOutput("upd_rerise", {23'd0, update_frame}, 24'd1);
            checkOutput("rdy_rerise", {23'd0, wr_ready}, 24'd1);
        end else begin
            checkOutput("upd_idle", {23'd0, update_frame}, 24'd0);
            checkOutput("busy_idle", {23'd0, frame_busy}, 24'd0);
        end
    endtask

    // Directed sequence covering reset, writes, frames, guard and errors.
    initial begin
        checks             = 0;
        errors             = 0;
        rst_n              = 1'b0;
        wr_valid           = 1'b0;
        wr_addr            = '0;
        wr_red             = '0;
        wr_green           = '0;
        wr_blue            = '0;
        commit             = 1'b0;
        program_led_number = '0;
        modelReset();

        tick();
        tick();
        checkOutput("rst_upd", {23'd0, update_frame}, 24'd0);
        checkOutput("rst_rdy", {23'd0, wr_ready}, 24'd1);
        checkOutput("rst_busy", {23'd0, frame_busy}, 24'd0);
        checkOutput("rst_err", {23'd0, wr_err}, 24'd0);
        for (int i = 0; i < MAXP; i++) readCheck("rst_rd", i);
        program_led_number = '0;
        rst_n = 1'b1;
        tick();

        // Write idx2 then commit; trigger one cycle after the commit edge.
        applyStimulus(1'b1, 3'd2, 8'h11, 8'h22, 8'h33, 1'b0);
        checkOutput("err_good_wr", {23'd0, wr_err}, 24'd0);
        program_led_number = '0;
        startFrame(1'b0, 3'd0, 8'd0, 8'd0, 8'd0);
        readCheck("rd_idx2", 2);
        readCheck("rd_idx0", 0);

        // Frame end and guard with nothing pending.
        sweepFrame(-1, -1);
        guardWait();

        // New frame, commit mid-frame; the write at idx3 is refused.
        startFrame(1'b0, 3'd0, 8'd0, 8'd0, 8'd0);
        readCheck("rd_f2_idx3", 3);
        readCheck("rd_f2_idx2", 2);
        sweepFrame(1, -1);
        guardWait();
        readCheck("rd_f3_idx2", 2);
        readCheck("rd_f3_idx3", 3);

        // Asynchronous reset in the middle of SENDING.
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("arst_upd", {23'd0, update_frame}, 24'd0);
        checkOutput("arst_rdy", {23'd0, wr_ready}, 24'd1);
        checkOutput("arst_busy", {23'd0, frame_busy}, 24'd0);
        for (int i = 0; i < MAXP; i++) readCheck("arst_rd", i);
        program_led_number = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Top in-range address stores; write and commit share a cycle.
        applyStimulus(1'b1, 3'd5, 8'h55, 8'h66, 8'h77, 1'b0);
        startFrame(1'b1, 3'd0, 8'hAA, 8'hBB, 8'hCC);
        readCheck("rd_simul_idx0", 0);
        readCheck("rd_idx5", 5);
        readCheck("rd_oob6", 6);
        readCheck("rd_oob7", 7);
        readCheck("rd_idx2_clear", 2);

        // Out-of-range write pulses wr_err for one cycle.
        applyStimulus(1'b1, 3'd6, 8'h12, 8'h34, 8'h56, 1'b0);
        checkOutput("err_pulse", {23'd0, wr_err}, 24'd1);
        tick();
        checkOutput("err_clear", {23'd0, wr_err}, 24'd0);

        // Two commits three cycles apart yield exactly one further frame.
        sweepFrame(1, 4);
        guardWait();
        for (int i = 0; i < MAXP; i++) readCheck("rd_after_dbl", i);
        sweepFrame(-1, -1);
        guardWait();
        repeat (4) tick();
        checkOutput("single_trigger", {23'd0, update_frame}, 24'd0);
        checkOutput("final_busy", {23'd0, frame_busy}, 24'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
